// File: rtl/mul_div_unit_pkg.sv
// Shared CPU definitions: multiply/divide op codes and mul/div FSM states.
// Also imported by the control unit.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    MULT  = 2'b00,
    MULTU = 2'b01,
    DIV   = 2'b10,
    DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int unsigned CNT_W = 6;

  function automatic logic is_div(input op_e op);
    return op[1];
  endfunction

  function automatic logic is_signed_op(input op_e op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the CPU control path and the mul/div unit.
interface mul_div_unit_if
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) ();

  logic               start;
  op_e                op;
  logic [WIDTH-1:0]   busA;
  logic [WIDTH-1:0]   busB;
  logic [2*WIDTH-1:0] result;
  logic               busy;
  logic               done;

  modport master (output start, op, busA, busB, input result, busy, done);
  modport slave  (input start, op, busA, busB, output result, busy, done);

endinterface

// File: rtl/mul_div_unit.sv
// Iterative 32-cycle multiplier / restoring divider with sign fix-up;
// a single 33-bit adder/subtractor serves both modes.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic           clk,
  input  logic           Reset,
  mul_div_unit_if.slave  mdu
);

  localparam int unsigned      W2       = 2 * WIDTH;
  localparam logic [CNT_W-1:0] LAST_IT  = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] FIX_NEG  = CNT_W'(WIDTH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              div_q, div_d;
  logic [W2-1:0]     acc_q, acc_d;
  logic [WIDTH-1:0]  opb_q, opb_d;
  logic              neg_q, neg_d;
  logic              rneg_q, rneg_d;
  logic [W2-1:0]     result_q, result_d;

  logic [WIDTH:0]    add_a, add_b, add_s;
  logic              add_sub;
  logic              sgn_a, sgn_b;
  logic [WIDTH-1:0]  mag_a, mag_b;
  logic [W2-1:0]     step_val, fix_val;
  logic [WIDTH-1:0]  quo_fix, rem_fix;

  always_comb begin
    sgn_a = is_signed_op(mdu.op) & mdu.busA[WIDTH-1];
    sgn_b = is_signed_op(mdu.op) & mdu.busB[WIDTH-1];
    mag_a = sgn_a ? -mdu.busA : mdu.busA;
    mag_b = sgn_b ? -mdu.busB : mdu.busB;
  end

  // Divide feeds the adder the remainder shifted left by one, keeping the
  // bit shifted out as the 33rd bit so a full 32-bit divisor never overflows.
  always_comb begin
    if (div_q) begin
      add_a   = {acc_q[W2-1], acc_q[W2-2:WIDTH-1]};
      add_b   = {1'b0, opb_q};
      add_sub = 1'b1;
    end else begin
      add_a   = {1'b0, acc_q[W2-1:WIDTH]};
      add_b   = acc_q[0] ? {1'b0, opb_q} : '0;
      add_sub = 1'b0;
    end
    add_s = add_a + (add_sub ? ~add_b : add_b) + {{WIDTH{1'b0}}, add_sub};

    if (div_q) begin
      if (!add_s[WIDTH]) step_val = {add_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else               step_val = {acc_q[W2-2:0], 1'b0};
    end else begin
      step_val = {add_s, acc_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    quo_fix = neg_q  ? -acc_q[WIDTH-1:0]  : acc_q[WIDTH-1:0];
    rem_fix = rneg_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    if (div_q) fix_val = {rem_fix, quo_fix};
    else       fix_val = neg_q ? -acc_q : acc_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    result_d = result_q;

    case (state_q)
      IDLE, DONE: begin
        if (mdu.start) begin
          state_d = CALC;
          cnt_d   = '0;
          div_d   = is_div(mdu.op);
          acc_d   = {{WIDTH{1'b0}}, mag_a};
          opb_d   = mag_b;
          neg_d   = sgn_a ^ sgn_b;
          rneg_d  = sgn_a;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        acc_d = step_val;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_IT) state_d = FIX;
      end
      // FIX spans two cycles: sign correction first, then the result write.
      FIX: begin
        if (cnt_q == FIX_NEG) begin
          acc_d = fix_val;
          cnt_d = cnt_q + 1'b1;
        end else begin
          result_d = acc_q;
          state_d  = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= 1'b0;
      acc_q    <= '0;
      opb_q    <= '0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      result_q <= result_d;
    end
  end

  assign mdu.result = result_q;
  assign mdu.busy   = (state_q == CALC) || (state_q == FIX);
  assign mdu.done   = (state_q == DONE);

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit with hand-computed expectations.
module tb_mul_div_unit;
  import mul_div_unit_pkg::*;

  logic clk = 1'b0;
  logic Reset;
  int   vectors = 0;
  int   miscompares = 0;

  mul_div_unit_if #(.WIDTH(32)) bus ();

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .Reset (Reset),
    .mdu   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog expired before summary");
    $fatal(1, "watchdog");
  end

  task automatic run_op(input op_e o, input logic [31:0] a, input logic [31:0] b,
                        output logic [63:0] res, output int lat, output int busy_n);
    @(negedge clk);
    bus.start = 1'b1; bus.op = o; bus.busA = a; bus.busB = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 0; busy_n = 0; res = '0;
    if (bus.busy) busy_n++;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) begin res = bus.result; break; end
      if (bus.busy) busy_n++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk); #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    vectors++; if (bus.result !== 64'h0) begin miscompares++; $display("FAIL reset_result got=%h exp=0", bus.result); end
    @(negedge clk); Reset = 1'b1;
  endtask

  task automatic test_mul();
    op_e         ops[4]  = '{MULTU, MULT, MULT, MULTU};
    logic [31:0] as[4]   = '{32'h7, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [31:0] bs[4]   = '{32'h6, 32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    logic [63:0] exps[4] = '{64'h2A, 64'h1, 64'h4000000000000000, 64'hFFFFFFFE00000001};
    logic [63:0] res;
    int lat, busy_n;
    for (int i = 0; i < 4; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, busy_n);
      vectors++; if (res !== exps[i]) begin miscompares++; $display("FAIL mul[%0d]_result got=%h exp=%h", i, res, exps[i]); end
      vectors++; if (lat != 34) begin miscompares++; $display("FAIL mul[%0d]_latency got=%0d exp=34", i, lat); end
      vectors++; if (busy_n != 34) begin miscompares++; $display("FAIL mul[%0d]_busy_cycles got=%0d exp=34", i, busy_n); end
    end
    repeat (3) @(posedge clk); #1;
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL done_single_cycle got=%b exp=0", bus.done); end
    vectors++; if (bus.result !== 64'hFFFFFFFE00000001) begin miscompares++; $display("FAIL result_hold_idle got=%h exp=fffffffe00000001", bus.result); end
  endtask

  task automatic test_div();
    op_e         ops[6]  = '{DIVU, DIV, DIV, DIVU, DIV, DIV};
    logic [31:0] as[6]   = '{32'd100, 32'hFFFFFFF9, 32'd7, 32'd5, 32'h80000000, 32'hFFFFFFFB};
    logic [31:0] bs[6]   = '{32'd7, 32'd2, 32'hFFFFFFFE, 32'd0, 32'hFFFFFFFF, 32'd0};
    logic [63:0] exps[6] = '{64'h00000002_0000000E, 64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                             64'h00000005_FFFFFFFF, 64'h00000000_80000000, 64'hFFFFFFFB_00000001};
    logic [63:0] res;
    int lat, busy_n;
    for (int i = 0; i < 6; i++) begin
      run_op(ops[i], as[i], bs[i], res, lat, busy_n);
      vectors++; if (res !== exps[i]) begin miscompares++; $display("FAIL div[%0d]_result got=%h exp=%h", i, res, exps[i]); end
      vectors++; if (lat != 34) begin miscompares++; $display("FAIL div[%0d]_latency got=%0d exp=34", i, lat); end
    end
  endtask

  task automatic test_ignore_busy();
    logic [63:0] prev;
    int lat = 0;
    prev = bus.result;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.busA = 32'd7; bus.busB = 32'd6;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (lat == 10) begin
        @(negedge clk);
        bus.start = 1'b1; bus.op = DIVU; bus.busA = 32'd9; bus.busB = 32'd3;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      lat++;
      if (lat == 5) begin
        vectors++; if (bus.result !== prev) begin miscompares++; $display("FAIL result_hold_calc got=%h exp=%h", bus.result, prev); end
      end
      if (bus.done) break;
    end
    vectors++; if (lat != 34) begin miscompares++; $display("FAIL ignore_busy_latency got=%0d exp=34", lat); end
    vectors++; if (bus.result !== 64'h2A) begin miscompares++; $display("FAIL ignore_busy_result got=%h exp=000000000000002a", bus.result); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res;
    int lat, busy_n;
    run_op(MULTU, 32'd3, 32'd5, res, lat, busy_n);
    vectors++; if (res !== 64'hF) begin miscompares++; $display("FAIL b2b_first_result got=%h exp=000000000000000f", res); end
    bus.start = 1'b1; bus.op = DIVU; bus.busA = 32'd100; bus.busB = 32'd7;
    @(posedge clk); #1;
    bus.start = 1'b0;
    vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL b2b_accept_busy got=%b exp=1", bus.busy); end
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      lat++;
      if (bus.done) break;
    end
    vectors++; if (lat != 34) begin miscompares++; $display("FAIL b2b_second_latency got=%0d exp=34", lat); end
    vectors++; if (bus.result !== 64'h00000002_0000000E) begin miscompares++; $display("FAIL b2b_second_result got=%h exp=000000020000000e", bus.result); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] res;
    int lat, busy_n;
    int seen = 0;
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULTU; bus.busA = 32'h12345; bus.busB = 32'h10;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (15) @(posedge clk);
    #3 Reset = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL midreset_busy got=%b exp=0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL midreset_done got=%b exp=0", bus.done); end
    vectors++; if (bus.result !== 64'h0) begin miscompares++; $display("FAIL midreset_result got=%h exp=0", bus.result); end
    repeat (2) @(negedge clk);
    Reset = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen++;
    end
    vectors++; if (seen != 0) begin miscompares++; $display("FAIL midreset_no_done got=%0d exp=0", seen); end
    run_op(DIVU, 32'd9, 32'd3, res, lat, busy_n);
    vectors++; if (res !== 64'h3) begin miscompares++; $display("FAIL post_reset_div got=%h exp=0000000000000003", res); end
    vectors++; if (lat != 34) begin miscompares++; $display("FAIL post_reset_latency got=%0d exp=34", lat); end
  endtask

  initial begin
    Reset     = 1'b0;
    bus.start = 1'b0;
    bus.op    = MULT;
    bus.busA  = '0;
    bus.busB  = '0;
    test_reset();
    test_mul();
    test_div();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width; only 32 is supported and verified.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle request pulse; sampled only when not busy.
REQ-005 SHALL have port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port busA  input  32  multiplicand or dividend.
REQ-007 SHALL have port busB  input  32  multiplier or divisor.
REQ-008 SHALL have port result  output  64  {HI,LO}; consumed by the HI/LO register on its MULT write.
REQ-009 SHALL have port busy  output  1  high while an operation is in flight.
REQ-010 SHALL have port done  output  1  one-cycle pulse when result becomes valid.

Function
REQ-011 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-012 IDLE or DONE with start=1 SHALL latch op, busA and busB, clear the iteration counter, and enter CALC; in IDLE with start=0 the FSM SHALL stay in IDLE.
REQ-013 In IDLE or DONE, the unit SHALL capture operand magnitudes: absolute values for signed ops and raw values for unsigned ops.
REQ-014 In IDLE or DONE, the unit SHALL also record the result signs: product sign = signA^signB; quotient sign = signA^signB; remainder sign = signA.
REQ-015 CALC SHALL perform exactly 32 iterations, one per cycle, using a 6-bit counter; after the 32nd iteration the FSM SHALL enter FIX.
REQ-016 Multiply SHALL be radix-2 shift-add with one multiplier bit per cycle, producing a 64-bit unsigned product.
REQ-017 Divide SHALL be restoring, producing one quotient bit per cycle, yielding a 32-bit unsigned quotient and remainder.
REQ-018 FIX SHALL apply two's-complement negation per the recorded signs, write result, and then enter DONE.
REQ-019 Result mapping: multiply → result = 64-bit product; divide → result[63:32] = remainder, result[31:0] = quotient.
REQ-020 Latency: start sampled at edge T0 → done=1 and result valid from edge T34 for exactly one cycle; busy=1 from edge T0 until edge T34.
REQ-021 In DONE, done SHALL be 1; with no start the FSM SHALL return to IDLE on the next edge.
REQ-022 result SHALL hold its value until the next FIX; it SHALL never change in IDLE, CALC or DONE.
REQ-023 start while busy=1 SHALL be ignored, with no effect on state, operands or result.
REQ-024 start in DONE SHALL be accepted, so back-to-back operations are spaced every 34 cycles.
REQ-025 Division by zero SHALL give, for the unsigned datapath, quotient 0xFFFFFFFF and remainder = |busA|; FIX sign rules then apply; no exception is raised.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL give quotient 0x80000000 and remainder 0; this is natural wrap and needs no special case.
REQ-027 MULT of the magnitude of 0x80000000 SHALL be computed as unsigned 0x80000000 with no overflow.

Reset
REQ-028 Reset=0 SHALL asynchronously force state IDLE, counter 0, busy 0, done 0, result 0, and all internal registers 0.
REQ-029 Reset asserted mid-CALC SHALL abandon the operation, and done SHALL NOT pulse for it.
REQ-030 After Reset deasserts, the first start SHALL be accepted on the first rising edge where Reset=1.

Structure
REQ-031 Op encodings (MULT, MULTU, DIV, DIVU) and the state encodings SHALL live in the shared CPU definitions package/header, also used by the control unit.
REQ-032 SHALL be a single module with no sub-module; the datapath SHALL use a 64-bit accumulator/remainder register, a 32-bit operand register, and one 33-bit adder/subtractor shared by both modes.

Verification
REQ-033 MULTU 0x00000007×0x00000006 → done at T34, result 0x000000000000002A; busy high for exactly 34 cycles.
REQ-034 MULT 0xFFFFFFFF×0xFFFFFFFF → 0x0000000000000001; MULT 0x80000000×0x80000000 → 0x4000000000000000; MULTU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE00000001.
REQ-035 DIVU 100/7 → result {0x00000002, 0x0000000E}; DIV -7/2 (0xFFFFFFF9/0x00000002) → {0xFFFFFFFF, 0xFFFFFFFD}; DIV 7/-2 → {0x00000001, 0xFFFFFFFD}.
REQ-036 DIVU 5/0 → {0x00000005, 0xFFFFFFFF}; DIV 0x80000000/0xFFFFFFFF → {0x00000000, 0x80000000}.
REQ-037 start pulsed at cycle 10 of a running MULTU with different operands → ignored; the original result is delivered; start in the DONE cycle → second op completes 34 cycles later.
REQ-038 Reset=0 asserted at cycle 15 of CALC → busy, done and result are 0 immediately (asynchronously); no done pulse follows; a new DIVU 9/3 after release → {0, 3}.
